// File: rtl/vec_stream_reader.sv
// Strided dual-bank operand fetch: issues 1-cycle-latency SRAM reads and streams
// {A,B} element pairs through a 3-entry output FIFO with start/busy/done control.
module vec_stream_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int MAX_ELEMENTS = 4096,
  parameter int FIFO_DEPTH   = 3,
  localparam int CNT_W       = $clog2(MAX_ELEMENTS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [CNT_W-1:0]      num_elements,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [7:0]            stride_a,
  input  logic [7:0]            stride_b,
  input  logic                  use_b,
  output logic                  mem_a_en,
  output logic [ADDR_WIDTH-1:0] mem_a_addr,
  input  logic [DATA_WIDTH-1:0] mem_a_rdata,
  output logic                  mem_b_en,
  output logic [ADDR_WIDTH-1:0] mem_b_addr,
  input  logic [DATA_WIDTH-1:0] mem_b_rdata,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  data_valid,
  input  logic                  data_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        num_q;
  logic [CNT_W-1:0]        issued;
  logic [7:0]              stride_a_q;
  logic [7:0]              stride_b_q;
  logic                    use_b_q;
  logic                    vld_p1;
  logic [1:0]              fifo_cnt;
  logic [DATA_WIDTH-1:0]   fa [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fb [FIFO_DEPTH];

  logic                    pop;
  logic [1:0]              cnt_nxt;
  logic [1:0]              wr_idx;
  logic                    room;
  logic                    issue;
  logic [DATA_WIDTH-1:0]   rd_b_p1;
  logic [DATA_WIDTH-1:0]   fa_n [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fb_n [FIFO_DEPTH];

  // Occupancy counts the FIFO after this edge plus the read still on the bus,
  // so a new issue never over-commits the 3 entries.
  assign pop     = data_valid && data_ready;
  assign cnt_nxt = fifo_cnt + 2'(vld_p1) - 2'(pop);
  assign room    = ({1'b0, cnt_nxt} + 3'(mem_a_en)) < 3'(FIFO_DEPTH);
  assign issue   = (state == RUN) && (issued < num_q) && room;
  assign wr_idx  = pop ? fifo_cnt - 2'd1 : fifo_cnt;
  assign rd_b_p1 = use_b_q ? mem_b_rdata : '0;
  assign data_a  = fa[0];
  assign data_b  = fb[0];

  // p1: capture returning read data; head-of-queue is always slot 0
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fa_n[i] = fa[i];
      fb_n[i] = fb[i];
    end
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        fa_n[i] = fa[i+1];
        fb_n[i] = fb[i+1];
      end
    end
    if (vld_p1 && wr_idx != 2'd3) begin
      fa_n[wr_idx] = mem_a_rdata;
      fb_n[wr_idx] = rd_b_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      num_q      <= '0;
      issued     <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      use_b_q    <= 1'b0;
      mem_a_en   <= 1'b0;
      mem_b_en   <= 1'b0;
      mem_a_addr <= '0;
      mem_b_addr <= '0;
      vld_p1     <= 1'b0;
      fifo_cnt   <= '0;
      data_valid <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fa[i] <= '0;
        fb[i] <= '0;
      end
    end else begin
      fifo_cnt   <= cnt_nxt;
      data_valid <= (cnt_nxt != 2'd0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fa[i] <= fa_n[i];
        fb[i] <= fb_n[i];
      end
      vld_p1   <= mem_a_en;
      done     <= 1'b0;
      mem_a_en <= 1'b0;
      mem_b_en <= 1'b0;

      // p0: issue stage, addresses advance from the previously issued one
      case (state)
        IDLE: begin
          if (start) begin
            num_q      <= num_elements;
            stride_a_q <= stride_a;
            stride_b_q <= stride_b;
            use_b_q    <= use_b;
            busy       <= 1'b1;
            if (num_elements == '0) begin
              issued <= '0;
              state  <= DONE;
              done   <= 1'b1;
            end else begin
              issued     <= CNT_W'(1);
              state      <= RUN;
              mem_a_en   <= 1'b1;
              mem_b_en   <= use_b;
              mem_a_addr <= base_a;
              mem_b_addr <= base_b;
            end
          end
        end
        RUN: begin
          if (issue) begin
            mem_a_en   <= 1'b1;
            mem_b_en   <= use_b_q;
            mem_a_addr <= mem_a_addr + ADDR_WIDTH'(stride_a_q);
            mem_b_addr <= mem_b_addr + ADDR_WIDTH'(stride_b_q);
            issued     <= issued + CNT_W'(1);
            if (issued + CNT_W'(1) == num_q) state <= DRAIN;
          end else if (issued == num_q) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mem_a_en && cnt_nxt == 2'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_stream_reader.sv
// Directed bench for vec_stream_reader: banked SRAM model, output/issue logging
// at the falling edge, and hand-computed expectations per scenario.
module tb_vec_stream_reader;

  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [CW-1:0] num_elements = '0;
  logic [15:0]   base_a = '0, base_b = '0;
  logic [7:0]    stride_a = '0, stride_b = '0;
  logic          use_b = 1'b0;
  logic          mem_a_en, mem_b_en;
  logic [15:0]   mem_a_addr, mem_b_addr;
  logic [7:0]    mem_a_rdata = '0, mem_b_rdata = '0;
  logic [7:0]    data_a, data_b;
  logic          data_valid;
  logic          data_ready = 1'b1;

  vec_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .num_elements(num_elements), .base_a(base_a), .base_b(base_b),
    .stride_a(stride_a), .stride_b(stride_b), .use_b(use_b),
    .mem_a_en(mem_a_en), .mem_a_addr(mem_a_addr), .mem_a_rdata(mem_a_rdata),
    .mem_b_en(mem_b_en), .mem_b_addr(mem_b_addr), .mem_b_rdata(mem_b_rdata),
    .data_a(data_a), .data_b(data_b), .data_valid(data_valid), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM banks with 1-cycle read latency; idle cycles return junk
  logic [7:0] bank_a [65536];
  logic [7:0] bank_b [65536];
  always @(posedge clk) begin
    mem_a_rdata <= mem_a_en ? bank_a[mem_a_addr] : 8'hA5;
    mem_b_rdata <= mem_b_en ? bank_b[mem_b_addr] : 8'h5A;
  end

  int          en_cyc_q [$];
  logic [15:0] addr_a_q [$];
  logic [15:0] addr_b_q [$];
  logic [7:0]  pop_a_q [$];
  logic [7:0]  pop_b_q [$];
  int          pop_cyc_q [$];
  int          done_cyc_q [$];
  int          nvalid = 0;

  always @(negedge clk) begin
    if (mem_a_en) begin en_cyc_q.push_back(cyc); addr_a_q.push_back(mem_a_addr); end
    if (mem_b_en) addr_b_q.push_back(mem_b_addr);
    if (data_valid) nvalid++;
    if (data_valid && data_ready) begin
      pop_a_q.push_back(data_a);
      pop_b_q.push_back(data_b);
      pop_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
  end

  int n_chk = 0;
  int n_bad = 0;
  int t0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_log();
    en_cyc_q.delete(); addr_a_q.delete(); addr_b_q.delete();
    pop_a_q.delete(); pop_b_q.delete(); pop_cyc_q.delete(); done_cyc_q.delete();
    nvalid = 0;
  endtask

  task automatic run_start(input int n, input logic [15:0] ba, input logic [15:0] bb,
                           input logic [7:0] sa, input logic [7:0] sb, input logic ub);
    @(posedge clk); #1;
    num_elements = CW'(n); base_a = ba; base_b = bb;
    stride_a = sa; stride_b = sb; use_b = ub; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < limit);
    check("idle_timeout", busy, 1'b0);
  endtask

  logic [7:0] e1a [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] e1b [4] = '{8'h00, 8'hFF, 8'hFE, 8'hFD};
  logic [7:0] e2a [3] = '{8'h11, 8'h22, 8'h33};
  logic [15:0] e2addr [3] = '{16'hFFFE, 16'h0001, 16'h0004};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      bank_a[16'h0010 + i] = e1a[i];
      bank_b[16'h0040 + i] = e1b[i];
    end
    bank_a[16'hFFFE] = 8'h11; bank_a[16'h0001] = 8'h22; bank_a[16'h0004] = 8'h33;
    for (int i = 0; i < 3; i++) bank_b[16'h0100 + i] = 8'h77;
    for (int i = 0; i < 8; i++) begin
      bank_a[16'h0200 + 2*i] = 8'(8'h50 + i);
      bank_b[16'h0300 + i]   = 8'(8'hA0 + i);
    end

    // reset state
    #22;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_a_en", mem_a_en, 1'b0);
    check("rst_b_en", mem_b_en, 1'b0);
    check("rst_addr_a", mem_a_addr, 16'h0);
    check("rst_data_a", data_a, 8'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // unit stride, 4 elements, A and B
    clear_log();
    run_start(4, 16'h0010, 16'h0040, 8'd1, 8'd1, 1'b1);
    wait_idle(50);
    check("t1_idle_cyc", cyc, t0 + 8);
    check("t1_npop", pop_a_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_a_q.size()) begin
        check("t1_a", pop_a_q[i], e1a[i]);
        check("t1_b", pop_b_q[i], e1b[i]);
        check("t1_pop_cyc", pop_cyc_q[i], t0 + 3 + i);
      end
      if (i < addr_a_q.size()) check("t1_addr_a", addr_a_q[i], 16'h0010 + i);
      if (i < addr_b_q.size()) check("t1_addr_b", addr_b_q[i], 16'h0040 + i);
    end
    check("t1_first_en", (en_cyc_q.size() > 0) ? en_cyc_q[0] : -1, t0 + 1);
    check("t1_ndone", done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0) check("t1_done_cyc", done_cyc_q[0], t0 + 7);

    // stride 3 with address wrap, unary (B not fetched)
    clear_log();
    run_start(3, 16'hFFFE, 16'h0100, 8'd3, 8'd1, 1'b0);
    wait_idle(50);
    check("t2_naddr", addr_a_q.size(), 3);
    check("t2_b_en", addr_b_q.size(), 0);
    check("t2_npop", pop_a_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < addr_a_q.size()) check("t2_addr_a", addr_a_q[i], e2addr[i]);
      if (i < pop_a_q.size()) begin
        check("t2_a", pop_a_q[i], e2a[i]);
        check("t2_b_zero", pop_b_q[i], 8'h00);
      end
    end

    // backpressure, 8 elements
    clear_log();
    data_ready = 1'b0;
    run_start(8, 16'h0200, 16'h0300, 8'd2, 8'd1, 1'b1);
    repeat (4) @(negedge clk);
    check("t3_valid_stall", data_valid, 1'b1);
    check("t3_head_a_early", data_a, 8'h50);
    repeat (5) @(negedge clk);
    check("t3_issued_max", en_cyc_q.size(), 3);
    check("t3_head_a_late", data_a, 8'h50);
    check("t3_head_b_late", data_b, 8'hA0);
    check("t3_no_pop", pop_a_q.size(), 0);
    @(posedge clk); #1; data_ready = 1'b1;
    wait_idle(100);
    check("t3_npop", pop_a_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < pop_a_q.size()) begin
        check("t3_a", pop_a_q[i], 8'h50 + i);
        check("t3_b", pop_b_q[i], 8'hA0 + i);
      end
    end
    if (addr_a_q.size() == 8) check("t3_last_addr_a", addr_a_q[7], 16'h020E);
    check("t3_ndone", done_cyc_q.size(), 1);

    // zero length
    clear_log();
    run_start(0, 16'h0010, 16'h0040, 8'd1, 8'd1, 1'b1);
    wait_idle(20);
    check("t4_no_en_a", en_cyc_q.size(), 0);
    check("t4_no_en_b", addr_b_q.size(), 0);
    check("t4_no_valid", nvalid, 0);
    check("t4_ndone", done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0) check("t4_done_cyc", done_cyc_q[0], t0 + 1);
    check("t4_idle_cyc", cyc, t0 + 2);

    // second start while busy is ignored
    clear_log();
    run_start(4, 16'h0010, 16'h0040, 8'd1, 8'd1, 1'b1);
    start = 1'b1; num_elements = CW'(2); base_a = 16'h0200; stride_a = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(50);
    check("t5_npop", pop_a_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < pop_a_q.size()) check("t5_a", pop_a_q[i], e1a[i]);
    check("t5_ndone", done_cyc_q.size(), 1);

    // restart right after returning to IDLE
    clear_log();
    run_start(2, 16'h0010, 16'h0040, 8'd1, 8'd1, 1'b1);
    wait_idle(50);
    check("t6_npop", pop_a_q.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < pop_a_q.size()) begin
        check("t6_a", pop_a_q[i], e1a[i]);
        check("t6_b", pop_b_q[i], e1b[i]);
      end
    check("t6_ndone", done_cyc_q.size(), 1);

    // asynchronous reset mid-run
    clear_log();
    run_start(8, 16'h0200, 16'h0300, 8'd2, 8'd1, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t7_busy", busy, 1'b0);
    check("t7_valid", data_valid, 1'b0);
    check("t7_a_en", mem_a_en, 1'b0);
    check("t7_b_en", mem_b_en, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_no_done", done_cyc_q.size(), 0);
    check("t7_busy_after", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_stream_reader.md
Name: vec_stream_reader

Overview:
- Operand fetch front-end for the vector engine.
- Reads up to two strided operand vectors from local SRAM banks (fixed 1-cycle read latency) and emits them as paired streaming elements (data_a/data_b with valid).
- Sits between the scratchpad and the vector engine's streaming inputs.
- Provides backpressure tolerance via a small output FIFO, and start/busy/done control matching the engines.

Parameters:
- DATA_WIDTH, 8, element width in bits
- ADDR_WIDTH, 16, SRAM word address width
- MAX_ELEMENTS, 4096, maximum vector length; CNT_W = $clog2(MAX_ELEMENTS)+1
- FIFO_DEPTH, 3, output buffer entries; fixed at 3, other values unsupported

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch request, sampled only in IDLE
- busy  output  1  high when state != IDLE
- done  output  1  one-cycle pulse in DONE state
- num_elements  input  CNT_W  elements to stream, 0..MAX_ELEMENTS
- base_a  input  ADDR_WIDTH  first address of operand A
- base_b  input  ADDR_WIDTH  first address of operand B
- stride_a  input  8  unsigned address increment per element, A
- stride_b  input  8  unsigned address increment per element, B
- use_b  input  1  1 = fetch B as well; 0 = unary op, B not read
- mem_a_en  output  1  read enable, bank A
- mem_a_addr  output  ADDR_WIDTH  read address, bank A
- mem_a_rdata  input  DATA_WIDTH  data valid the cycle after mem_a_en
- mem_b_en  output  1  read enable, bank B
- mem_b_addr  output  ADDR_WIDTH  read address, bank B
- mem_b_rdata  input  DATA_WIDTH  data valid the cycle after mem_b_en
- data_a  output  DATA_WIDTH  FIFO head, operand A
- data_b  output  DATA_WIDTH  FIFO head, operand B (0 when use_b=0)
- data_valid  output  1  FIFO non-empty
- data_ready  input  1  consumer accepts the head this cycle

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0, data_valid=0, mem_a_en=0, mem_b_en=0; addresses, data_a, data_b = 0. FIFO, counters and in-flight flag cleared. Reset mid-run aborts with no done pulse.
- Configuration latching: num_elements, bases, strides and use_b are latched on the accepted start. Input changes while busy are ignored. A start while busy is ignored.
- States: IDLE -> RUN on start with num_elements>0. IDLE -> DONE on start with num_elements==0 (no reads). RUN -> DRAIN when the last read is issued. DRAIN -> DONE when the FIFO is empty and nothing is in flight. DONE -> IDLE unconditionally after 1 cycle.
- Issue rule (RUN): issue one read per cycle when issued < num and fifo_count + inflight < FIFO_DEPTH. data_ready must not feed mem_*_en combinationally.
- Issue signals: mem_a_en=1 on each issue; mem_b_en = use_b on each issue.
- Address generation: element i uses base_a + i*stride_a and base_b + i*stride_b, computed incrementally. Addresses wrap modulo 2^ADDR_WIDTH. Stride 0 is legal (broadcast).
- Read capture: data returned the cycle after issue is written into the FIFO as an {A,B} pair. B is forced to 0 when use_b=0.
- FIFO: pop when data_valid && data_ready. Push and pop in the same cycle are both honoured. Elements are emitted in issue order; no drop, no duplicate.
- Latency: start in cycle T -> first mem_*_en in T+1 -> first data_valid in T+3 (registered FIFO head).
- Throughput: with data_ready held high, one element per cycle sustained.
- Backpressure: with data_ready low, issue stalls once 3 entries are occupied or in flight. The FIFO never overflows.
- Output stability: data_a/data_b remain stable while data_valid=1 and data_ready=0.
- done and busy: done is high exactly one cycle, after the final pop; busy=1 during DONE.

Test Plan:
- Unit stride, 4 elements: base_a=0x10, base_b=0x40, stride 1, use_b=1, ready=1; mem A[i]=i+1, B[i]=-i. Expect pairs (1,0),(2,-1),(3,-2),(4,-3) on consecutive cycles from T+3, then done one cycle after the last pop, then busy=0.
- Strided and wrap, 3 elements: base_a=0xFFFE, stride_a=3, use_b=0. Expect addresses 0xFFFE, 0x0001, 0x0004, mem_b_en never asserted, and data_b=0 on all outputs.
- Backpressure, 8 elements: ready=0 for 10 cycles, then 1. Expect at most 3 reads issued before release, head held stable while stalled, and all 8 elements in order with no loss.
- Zero length: start with num_elements=0. Expect no mem_*_en, data_valid=0, and done pulse in cycle T+1.
- Restart/ignore: a second start mid-run is ignored, and a new start right after returning to IDLE is accepted. Separately, asserting rst_n=0 mid-run drops data_valid, mem enables and busy immediately, with no done pulse.
